// File: rtl/dmem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge_pkg
// Brief    : Shared FSM state encoding and constants for the data-memory bridge.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_bridge_pkg;

  localparam int c_strb_w = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge_if
// Brief    : Valid/ready request channel and response channel to data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_bridge_if #(
  parameter int XLEN = 32
) ();
  logic            bus_req_valid;
  logic            bus_req_ready;
  logic [XLEN-1:0] bus_req_addr;
  logic            bus_req_wen;
  logic [3:0]      bus_req_wstrb;
  logic [XLEN-1:0] bus_req_wdata;
  logic            bus_rsp_valid;
  logic [XLEN-1:0] bus_rsp_rdata;

  modport master (
    output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wstrb, bus_req_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wstrb, bus_req_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : dmem_timeout_cnt
// Brief    : WAIT-cycle counter with terminal-count flag at TIMEOUT_CYCLES-1.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES) + 1;

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + c_cnt_w'(1);
    end
  end

  assign terminal = (r_count == c_cnt_w'(TIMEOUT_CYCLES - 1));
endmodule
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge
// Brief    : Bridges the core's combinational data request onto a valid/ready
//            memory bus, stalling the pipeline until the response completes.
//            Optional WAIT timeout enabled by DMEM_BRIDGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                data_valid,
  input  logic                data_wen,
  input  logic [c_strb_w-1:0] data_wstrb,
  input  logic [XLEN-1:0]     data_wdata,
  input  logic [XLEN-1:0]     data_addr,
  output logic [XLEN-1:0]     data_rdata,
  output logic                data_stall,
  output logic                data_err,
  dmem_bridge_if.master       bus
);

  state_t r_state;
  state_t w_next;
  logic   w_req_valid;
  logic   w_complete;
  logic   w_timeout;
  logic   w_out_valid;
  logic   w_unused_addr;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Responses outside WAIT fall through untouched: no state change.
  always_comb begin
    w_next      = r_state;
    w_req_valid = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_valid = data_valid;
        if (data_valid) begin
          w_next = bus.bus_req_ready ? WAIT : REQ;
        end
      end
      REQ: begin
        w_req_valid = 1'b1;
        if (bus.bus_req_ready) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.bus_rsp_valid || w_timeout) begin
          w_complete = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs held at their reset values while rst_b is asserted.
  assign w_out_valid       = rst_b & w_req_valid;
  assign bus.bus_req_valid = w_out_valid;
  assign bus.bus_req_addr  = w_out_valid ? {data_addr[XLEN-1:2], 2'b00} : '0;
  assign bus.bus_req_wen   = w_out_valid & data_wen;
  assign bus.bus_req_wstrb = (w_out_valid & data_wen) ? data_wstrb : '0;
  assign bus.bus_req_wdata = w_out_valid ? data_wdata : '0;

  assign data_stall = rst_b & data_valid & ~w_complete;
  assign data_rdata = (rst_b & w_complete & bus.bus_rsp_valid) ? bus.bus_rsp_rdata : '0;
  assign w_unused_addr = ^data_addr[1:0];

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  logic w_cnt_clear;
  logic w_cnt_en;
  logic w_terminal;

  assign w_cnt_clear = (r_state != WAIT) && (w_next == WAIT);
  assign w_cnt_en    = (r_state == WAIT);

  if (1) begin : g_timeout
    dmem_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
      .clk      (clk),
      .rst_b    (rst_b),
      .clear    (w_cnt_clear),
      .enable   (w_cnt_en),
      .terminal (w_terminal)
    );
  end

  // A response arriving with the terminal count wins over the timeout.
  assign w_timeout = (r_state == WAIT) & w_terminal;
  assign data_err  = rst_b & w_complete & ~bus.bus_rsp_valid;
`else
  logic w_unused_timeout_cfg;

  assign w_timeout            = 1'b0;
  assign data_err             = 1'b0;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

`ifndef SYNTHESIS
  a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_b)
    bus.bus_rsp_valid |-> (r_state == WAIT))
    else $warning("dmem_bridge: stray bus response ignored");
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bridge
// Brief    : Self-checking bench: directed vector table, timeout sequence and
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_bridge;

  localparam int XLEN = 32;
  localparam int T    = 8;
  localparam int NVEC = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_b;
  logic            data_valid;
  logic            data_wen;
  logic [3:0]      data_wstrb;
  logic [XLEN-1:0] data_wdata;
  logic [XLEN-1:0] data_addr;
  logic [XLEN-1:0] data_rdata;
  logic            data_stall;
  logic            data_err;

  dmem_bridge_if #(.XLEN(XLEN)) bus_if ();

  dmem_bridge #(
    .XLEN           (XLEN),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .data_valid (data_valid),
    .data_wen   (data_wen),
    .data_wstrb (data_wstrb),
    .data_wdata (data_wdata),
    .data_addr  (data_addr),
    .data_rdata (data_rdata),
    .data_stall (data_stall),
    .data_err   (data_err),
    .bus        (bus_if)
  );

  typedef struct {
    logic        rst_b;
    logic        dv;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        rdy;
    logic        rsp;
    logic [31:0] rsp_data;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t tbl [NVEC];

  int checks = 0;
  int errors = 0;

  // Reference model: is a transaction accepted and awaiting its response,
  // and how many WAIT cycles have elapsed since acceptance.
  bit m_busy = 1'b0;
  int m_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    logic        tmo, done, e_rv, e_stall, e_err;
    logic [31:0] e_rdata;
    tmo = 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    tmo = m_busy && (m_cnt == T - 1);
`endif
    done    = m_busy && (bus_if.bus_rsp_valid || tmo);
    e_rv    = rst_b && !m_busy && data_valid;
    e_stall = rst_b && data_valid && !done;
    e_rdata = (rst_b && done && bus_if.bus_rsp_valid) ? bus_if.bus_rsp_rdata : 32'h0;
    e_err   = rst_b && done && !bus_if.bus_rsp_valid;
    #3;
    chk("rnd.req_valid", {31'b0, bus_if.bus_req_valid}, {31'b0, e_rv});
    chk("rnd.req_addr", bus_if.bus_req_addr, e_rv ? {data_addr[31:2], 2'b00} : 32'h0);
    chk("rnd.req_wen", {31'b0, bus_if.bus_req_wen}, {31'b0, e_rv && data_wen});
    chk("rnd.req_wstrb", {28'b0, bus_if.bus_req_wstrb}, (e_rv && data_wen) ? {28'b0, data_wstrb} : 32'h0);
    chk("rnd.req_wdata", bus_if.bus_req_wdata, e_rv ? data_wdata : 32'h0);
    chk("rnd.stall", {31'b0, data_stall}, {31'b0, e_stall});
    chk("rnd.rdata", data_rdata, e_rdata);
    chk("rnd.err", {31'b0, data_err}, {31'b0, e_err});
    if (!rst_b) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (done) m_busy = 1'b0;
      else m_cnt++;
    end else if (data_valid && bus_if.bus_req_ready) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end
    tick();
  endtask

  initial begin
    logic hold;

    //          rst  dv wen strb   wdata         addr          rdy rsp rsp_data     | rv addr          wen strb  wdata         stall rdata        err
    tbl[0]  = '{1'b0,1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b0,32'h0,        1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b1,4'hF,32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,1'b1,32'hFFFFFFFF, 1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b0,32'h0,        1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b0,32'h0,        1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b0,4'hF,32'h0,        32'h1003,     1'b1,1'b0,32'h0,        1'b1,32'h1000,     1'b0,4'h0,32'h0,        1'b1,32'h0,        1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0,4'hF,32'h0,        32'h1003,     1'b1,1'b1,32'hDEADBEEF, 1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b0,32'hDEADBEEF, 1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b0,32'h0,        1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b1,4'h4,32'hA5A5A5A5, 32'h2006,     1'b0,1'b0,32'h0,        1'b1,32'h2004,     1'b1,4'h4,32'hA5A5A5A5, 1'b1,32'h0,        1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b1,4'h4,32'hA5A5A5A5, 32'h2006,     1'b0,1'b1,32'hBADBAD00, 1'b1,32'h2004,     1'b1,4'h4,32'hA5A5A5A5, 1'b1,32'h0,        1'b0};
    tbl[8]  = '{1'b1,1'b1,1'b1,4'h4,32'hA5A5A5A5, 32'h2006,     1'b0,1'b0,32'h0,        1'b1,32'h2004,     1'b1,4'h4,32'hA5A5A5A5, 1'b1,32'h0,        1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b1,4'h4,32'hA5A5A5A5, 32'h2006,     1'b1,1'b0,32'h0,        1'b1,32'h2004,     1'b1,4'h4,32'hA5A5A5A5, 1'b1,32'h0,        1'b0};
    tbl[10] = '{1'b1,1'b1,1'b1,4'h4,32'hA5A5A5A5, 32'h2006,     1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b1,32'h0,        1'b0};
    tbl[11] = '{1'b1,1'b1,1'b1,4'h4,32'hA5A5A5A5, 32'h2006,     1'b0,1'b1,32'h12345678, 1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b0,32'h12345678, 1'b0};
    tbl[12] = '{1'b1,1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b0,1'b1,32'hCAFEF00D, 1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b0,32'h0,        1'b0};
    tbl[13] = '{1'b1,1'b1,1'b0,4'hF,32'h0,        32'h3000,     1'b1,1'b0,32'h0,        1'b1,32'h3000,     1'b0,4'h0,32'h0,        1'b1,32'h0,        1'b0};
    tbl[14] = '{1'b1,1'b1,1'b0,4'hF,32'h0,        32'h3000,     1'b0,1'b1,32'h11111111, 1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b0,32'h11111111, 1'b0};
    tbl[15] = '{1'b1,1'b1,1'b0,4'hF,32'h0,        32'h3004,     1'b1,1'b0,32'h0,        1'b1,32'h3004,     1'b0,4'h0,32'h0,        1'b1,32'h0,        1'b0};
    tbl[16] = '{1'b1,1'b1,1'b0,4'hF,32'h0,        32'h3004,     1'b0,1'b1,32'h22222222, 1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b0,32'h22222222, 1'b0};
    tbl[17] = '{1'b1,1'b1,1'b0,4'hF,32'h0,        32'h4000,     1'b1,1'b1,32'hFFFFFFFF, 1'b1,32'h4000,     1'b0,4'h0,32'h0,        1'b1,32'h0,        1'b0};
    tbl[18] = '{1'b1,1'b1,1'b0,4'hF,32'h0,        32'h4000,     1'b0,1'b1,32'h33333333, 1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b0,32'h33333333, 1'b0};
    tbl[19] = '{1'b1,1'b1,1'b0,4'hF,32'h0,        32'h5000,     1'b1,1'b0,32'h0,        1'b1,32'h5000,     1'b0,4'h0,32'h0,        1'b1,32'h0,        1'b0};
    tbl[20] = '{1'b0,1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b0,32'h0,        1'b0};
    tbl[21] = '{1'b1,1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b0,1'b1,32'h44444444, 1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b0,32'h0,        1'b0};
    tbl[22] = '{1'b1,1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,4'h0,32'h0,        1'b0,32'h0,        1'b0};

    for (int i = 0; i < NVEC; i++) begin
      rst_b                = tbl[i].rst_b;
      data_valid           = tbl[i].dv;
      data_wen             = tbl[i].wen;
      data_wstrb           = tbl[i].wstrb;
      data_wdata           = tbl[i].wdata;
      data_addr            = tbl[i].addr;
      bus_if.bus_req_ready = tbl[i].rdy;
      bus_if.bus_rsp_valid = tbl[i].rsp;
      bus_if.bus_rsp_rdata = tbl[i].rsp_data;
      #3;
      chk($sformatf("vec%0d.req_valid", i), {31'b0, bus_if.bus_req_valid}, {31'b0, tbl[i].e_rv});
      chk($sformatf("vec%0d.req_addr", i), bus_if.bus_req_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d.req_wen", i), {31'b0, bus_if.bus_req_wen}, {31'b0, tbl[i].e_wen});
      chk($sformatf("vec%0d.req_wstrb", i), {28'b0, bus_if.bus_req_wstrb}, {28'b0, tbl[i].e_wstrb});
      chk($sformatf("vec%0d.req_wdata", i), bus_if.bus_req_wdata, tbl[i].e_wdata);
      chk($sformatf("vec%0d.stall", i), {31'b0, data_stall}, {31'b0, tbl[i].e_stall});
      chk($sformatf("vec%0d.rdata", i), data_rdata, tbl[i].e_rdata);
      chk($sformatf("vec%0d.err", i), {31'b0, data_err}, {31'b0, tbl[i].e_err});
      tick();
    end

    // Accepted load that receives no response for T WAIT cycles.
    rst_b = 1'b1; data_valid = 1'b1; data_wen = 1'b0; data_wstrb = 4'hF;
    data_wdata = 32'h0; data_addr = 32'h6008;
    bus_if.bus_req_ready = 1'b1; bus_if.bus_rsp_valid = 1'b0; bus_if.bus_rsp_rdata = 32'h0;
    #3;
    chk("tmo.accept_valid", {31'b0, bus_if.bus_req_valid}, 32'd1);
    chk("tmo.accept_stall", {31'b0, data_stall}, 32'd1);
    tick();
    bus_if.bus_req_ready = 1'b0;
    for (int i = 0; i < T; i++) begin
      #3;
      chk($sformatf("tmo.wait%0d_valid", i), {31'b0, bus_if.bus_req_valid}, 32'd0);
      chk($sformatf("tmo.wait%0d_rdata", i), data_rdata, 32'd0);
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      chk($sformatf("tmo.wait%0d_stall", i), {31'b0, data_stall}, (i == T - 1) ? 32'd0 : 32'd1);
      chk($sformatf("tmo.wait%0d_err", i), {31'b0, data_err}, (i == T - 1) ? 32'd1 : 32'd0);
`else
      chk($sformatf("tmo.wait%0d_stall", i), {31'b0, data_stall}, 32'd1);
      chk($sformatf("tmo.wait%0d_err", i), {31'b0, data_err}, 32'd0);
`endif
      tick();
    end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    data_valid = 1'b0;
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'h55AA55AA;
    #3;
    chk("tmo.late_stall", {31'b0, data_stall}, 32'd0);
    chk("tmo.late_rdata", data_rdata, 32'd0);
    chk("tmo.late_err", {31'b0, data_err}, 32'd0);
`else
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'h55AA55AA;
    #3;
    chk("tmo.rsp_stall", {31'b0, data_stall}, 32'd0);
    chk("tmo.rsp_rdata", data_rdata, 32'h55AA55AA);
    chk("tmo.rsp_err", {31'b0, data_err}, 32'd0);
`endif
    tick();
    data_valid = 1'b0; bus_if.bus_rsp_valid = 1'b0;
    #3;
    chk("tmo.idle_stall", {31'b0, data_stall}, 32'd0);
    tick();

    // Randomized traffic: the core holds its request while stalled.
    rst_b = 1'b0; data_valid = 1'b0;
    step();
    hold = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      rst_b = ($urandom_range(0, 99) != 0);
      if (!hold) begin
        data_valid = ($urandom_range(0, 2) != 0);
        data_wen   = 1'($urandom_range(0, 1));
        data_wstrb = 4'($urandom_range(0, 15));
        data_wdata = $urandom;
        data_addr  = $urandom;
      end
      bus_if.bus_req_ready = 1'($urandom_range(0, 1));
      bus_if.bus_rsp_valid = m_busy && ($urandom_range(0, 3) == 0);
      bus_if.bus_rsp_rdata = $urandom;
      step();
      hold = data_stall;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
